// File: rtl/vga_pattern_gen.sv
// Registered VGA test-pattern generator: stripes, checkerboard, scrolling stripes, colour bars, solid.
// Optional build macro VGA_PATTERN_BORDER_EN forces a white one-pixel border around the active area.
module vga_pattern_gen #(
  parameter int CW          = 4,
  parameter int STRIPE_LOG2 = 4,
  parameter int HACT        = 640,
  parameter int VACT        = 480,
  parameter int SCROLL_DIV  = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            vidon,
  input  logic [10:0]     hc,
  input  logic [10:0]     vc,
  input  logic [2:0]      mode,
  input  logic            scroll_en,
  input  logic [3*CW-1:0] fg_color,
  input  logic [3*CW-1:0] bg_color,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic            frame_tick
);

  localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [2:0] {
    M_HSTRIPE  = 3'd0,
    M_VSTRIPE  = 3'd1,
    M_CHECKER  = 3'd2,
    M_HSCROLL  = 3'd3,
    M_VSCROLL  = 3'd4,
    M_BARS     = 3'd5,
    M_SOLID    = 3'd6,
    M_RESERVED = 3'd7
  } mode_e;

  mode_e           r_mode;
  logic [10:0]     r_scroll;
  logic [DW-1:0]   r_div;
  logic [3*CW-1:0] r_rgb;
  logic            r_tick;

  logic            w_eof;
  logic [10:0]     w_hs;
  logic [10:0]     w_vs;
  logic [2:0]      w_bar;
  logic            w_p;
  logic [3*CW-1:0] w_rgb;

  assign w_eof = vidon && (hc == 11'(HACT - 1)) && (vc == 11'(VACT - 1));
  assign w_hs  = hc + r_scroll;
  assign w_vs  = vc + r_scroll;

  // Bar index counts how many of the seven HACT/8 thresholds the column has passed.
  always_comb begin
    w_bar = '0;
    for (int unsigned j = 1; j < 8; j++) begin
      if (32'(hc) >= j * 32'(HACT / 8))
        w_bar = w_bar + 3'd1;
    end
  end

  always_comb begin
    w_p   = 1'b0;
    w_rgb = '0;
    case (r_mode)
      M_HSTRIPE: w_p = vc[STRIPE_LOG2];
      M_VSTRIPE: w_p = hc[STRIPE_LOG2];
      M_CHECKER: w_p = hc[STRIPE_LOG2] ^ vc[STRIPE_LOG2];
      M_HSCROLL: w_p = w_vs[STRIPE_LOG2];
      M_VSCROLL: w_p = w_hs[STRIPE_LOG2];
      M_SOLID:   w_p = 1'b1;
      default:   w_p = 1'b0;
    endcase
    if (r_mode == M_BARS)
      w_rgb = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
    else if (r_mode != M_RESERVED)
      w_rgb = w_p ? fg_color : bg_color;
`ifdef VGA_PATTERN_BORDER_EN
    if ((hc == 11'd0) || (hc == 11'(HACT - 1)) || (vc == 11'd0) || (vc == 11'(VACT - 1)))
      w_rgb = '1;
`endif
    if (!vidon)
      w_rgb = '0;
  end

  // Mode and scroll only move at end of frame so the frame being drawn never tears.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_rgb    <= '0;
      r_tick   <= 1'b0;
      r_mode   <= M_HSTRIPE;
      r_scroll <= '0;
      r_div    <= '0;
    end else begin
      r_rgb  <= w_rgb;
      r_tick <= w_eof;
      if (w_eof) begin
        r_mode <= mode_e'(mode);
        if (scroll_en) begin
          if (r_div == DW'(SCROLL_DIV - 1)) begin
            r_div    <= '0;
            r_scroll <= r_scroll + 11'd1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
      end
    end
  end

  assign red        = r_rgb[3*CW-1:2*CW];
  assign green      = r_rgb[2*CW-1:CW];
  assign blue       = r_rgb[CW-1:0];
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen (CW=4, 640x480, SCROLL_DIV=2); honours VGA_PATTERN_BORDER_EN.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        clr;
  logic        vidon;
  logic [10:0] hc, vc;
  logic [2:0]  mode;
  logic        scroll_en;
  logic [11:0] fg_color, bg_color;
  logic [3:0]  red, green, blue;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        tick;
    bit          chk;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  vga_pattern_gen #(
    .CW(4), .STRIPE_LOG2(4), .HACT(640), .VACT(480), .SCROLL_DIV(2)
  ) dut (
    .clk(clk), .clr(clr), .vidon(vidon), .hc(hc), .vc(vc),
    .mode(mode), .scroll_en(scroll_en), .fg_color(fg_color), .bg_color(bg_color),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [11:0] rgb_e, input logic tick_e);
    checks++;
    if ({red, green, blue} !== rgb_e || frame_tick !== tick_e) begin
      failures++;
      $display("FAIL %s: got rgb=%h tick=%b, expected rgb=%h tick=%b",
               name, {red, green, blue}, frame_tick, rgb_e, tick_e);
    end
  endtask

  // Monitor: every driven cycle produces exactly one output one clock later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) compare(e.name, e.rgb, e.tick);
    end
  end

  function automatic logic on_edge(input logic vid, input logic [10:0] h, input logic [10:0] v);
`ifdef VGA_PATTERN_BORDER_EN
    return vid && (h == 11'd0 || h == 11'd639 || v == 11'd0 || v == 11'd479);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic vid, input logic [10:0] h, input logic [10:0] v,
                      input logic [11:0] rgb_e, input logic tick_e, input bit chk,
                      input string name);
    exp_t e;
    @(negedge clk);
    vidon = vid; hc = h; vc = v;
    e.rgb  = on_edge(vid, h, v) ? 12'hFFF : rgb_e;
    e.tick = tick_e;
    e.chk  = chk;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic eof(input logic [11:0] rgb_e, input bit chk, input string name);
    step(1'b1, 11'd639, 11'd479, rgb_e, 1'b1, chk, name);
  endtask

  initial begin
    clr = 1'b1; vidon = 1'b0; hc = '0; vc = '0; mode = 3'd0; scroll_en = 1'b0;
    fg_color = 12'hF00; bg_color = 12'h000;
    repeat (2) @(posedge clk);
    #1 compare("reset_state", 12'h000, 1'b0);
    @(negedge clk) clr = 1'b0;

    // Async reset mid-line while red is lit
    step(1, 5, 16, 12'hF00, 0, 1, "pre_reset_red");
    #2 clr = 1'b1;
    #1 compare("async_reset", 12'h000, 1'b0);
    @(negedge clk) clr = 1'b0;
    step(0, 5, 16, 12'h000, 0, 1, "blank0");
    step(0, 639, 479, 12'h000, 0, 1, "blank_no_tick");

    // Mode 0 stripes
    fg_color = 12'hFF0; bg_color = 12'h000;
    step(1, 5, 15, 12'h000, 0, 1, "m0_vc15");
    step(1, 5, 16, 12'hFF0, 0, 1, "m0_vc16");
    step(1, 5, 32, 12'h000, 0, 1, "m0_vc32");

    // Mode request mid-frame only takes effect after EOF
    bg_color = 12'h00F; mode = 3'd2;
    step(1, 16, 100, 12'h00F, 0, 1, "latch_vc100");
    step(1, 16, 112, 12'hFF0, 0, 1, "latch_vc112");
    eof(12'hFF0, 1, "latch_eof");
    step(0, 0, 0, 12'h000, 0, 1, "tick_one_cycle");
    step(1, 16, 0, 12'hFF0, 0, 1, "m2_16_0");
    step(1, 16, 16, 12'h00F, 0, 1, "m2_16_16");

    // Scrolling stripes, SCROLL_DIV=2
    mode = 3'd3; fg_color = 12'h0F0; bg_color = 12'h000;
    eof(12'h000, 1, "m2_eof");
    scroll_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      int s;
      s = (f < 2) ? 0 : (f < 4) ? 1 : 2;
      step(1, 0, 14, (s == 2) ? 12'h0F0 : 12'h000, 0, 1, $sformatf("scr_f%0d_vc14", f));
      step(1, 0, 15, (s >= 1) ? 12'h0F0 : 12'h000, 0, 1, $sformatf("scr_f%0d_vc15", f));
      eof((s == 0) ? 12'h0F0 : 12'h000, 1, $sformatf("scr_f%0d_eof", f));
    end
    // scroll=2, div=1: 4089 more EOFs land on scroll=2047
    for (int i = 0; i < 4089; i++) eof(12'h000, 0, "adv");
    step(1, 5, 0, 12'h0F0, 0, 1, "scr2047_vc0");
    step(1, 5, 1, 12'h000, 0, 1, "scr2047_vc1");
    eof(12'h000, 0, "adv");
    eof(12'h000, 0, "adv");
    step(1, 5, 0, 12'h000, 0, 1, "wrap_vc0");
    step(1, 5, 16, 12'h0F0, 0, 1, "wrap_vc16");

    // Colour bars ignore fg/bg
    scroll_en = 1'b0; mode = 3'd5; fg_color = 12'h123; bg_color = 12'h456;
    eof(12'h000, 0, "to_bars");
    step(1, 0, 200, 12'h000, 0, 1, "bar_hc0");
    step(1, 79, 200, 12'h000, 0, 1, "bar_hc79");
    step(1, 80, 200, 12'h00F, 0, 1, "bar_hc80");
    step(1, 160, 200, 12'h0F0, 0, 1, "bar_hc160");
    step(1, 639, 200, 12'hFFF, 0, 1, "bar_hc639");

    // Reserved mode and solid
    mode = 3'd7;
    eof(12'h000, 0, "to_m7");
    step(1, 0, 200, 12'h000, 0, 1, "m7_edge");
    step(1, 320, 240, 12'h000, 0, 1, "m7_center");
    mode = 3'd6;
    eof(12'h000, 0, "to_m6");
    step(1, 320, 240, 12'h123, 0, 1, "m6_solid");
    step(0, 320, 240, 12'h000, 0, 1, "m6_blank");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
